// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 width codes and FSM state encoding shared by the data-memory access unit.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load lane extract/extend and sub-word store merge against a full RAM word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load,
  output logic [31:0] merged
);
  logic [4:0]  bsh, hsh, sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  assign bsh = {off, 3'b000};
  assign hsh = {off[1], 4'b0000};
  assign b = 8'(word >> bsh);
  assign h = 16'(word >> hsh);
  assign load = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'h0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'h0, h} : word;
  assign sh = funct3[1:0] == 2'd0 ? bsh : funct3[1:0] == 2'd1 ? hsh : 5'd0;
  assign mask = funct3[1:0] == 2'd0 ? 32'h0000_00ff << bsh :
                funct3[1:0] == 2'd1 ? 32'h0000_ffff << hsh : 32'hffff_ffff;
  assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: single-outstanding RISC-V load/store front end for a single-port write-first BRAM,
// doing read-modify-write for sub-word stores.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter  int RAM_DEPTH    = 1024,
  parameter  int READ_LATENCY = 2,
  localparam int AW           = $clog2(RAM_DEPTH)
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic          ram_we,
  output logic          ram_en,
  output logic          ram_regce,
  output logic          ram_rst,
  input  logic [31:0]   ram_dout
);
  state_t        state, state_n;
  logic [1:0]    cnt;
  logic          store_q, err_q, bad;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, data_q, load, merged;
  assign bad = req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11 || (req_store && req_funct3[2]) ||
               (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3 == F3_W && req_addr[1:0] != 2'd0);
  dmem_lane_align u_align (
    .word(ram_dout), .wdata(wdata_q), .off(addr_q[1:0]), .funct3(f3_q), .load(load), .merged(merged)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = bad ? RESP : ISSUE;
      ISSUE:   state_n = (store_q && f3_q == F3_W) ? RESP : WAIT;
      WAIT:    if (cnt == 2'd0) state_n = store_q ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        store_q <= req_store;
        err_q   <= bad;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      if (state == ISSUE) cnt <= 2'(READ_LATENCY - 1);
      else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      // final WAIT cycle: RAM output is valid, capture extended load or merged store word
      if (state == WAIT && cnt == 2'd0) data_q <= store_q ? merged : load;
    end
  end
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !store_q && !err_q) ? data_q : 32'h0;
  assign ram_addr   = addr_q[AW+1:2];
  assign ram_en     = state == ISSUE || state == WRITE;
  assign ram_we     = state == WRITE || (state == ISSUE && store_q && f3_q == F3_W);
  assign ram_regce  = state == WAIT;
  assign ram_din    = state == WRITE ? data_q : wdata_q;
  assign ram_rst    = rsta;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized and directed checks of two units (READ_LATENCY 2 and 1) against
// write-first BRAM models and a word-array reference model.
module tb_dmem_access_unit;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  logic        clka;
  logic [1:0]  rsta, req_valid, req_ready, req_store, resp_valid, resp_ready, resp_err;
  logic [1:0]  ram_we, ram_en, ram_regce, ram_rst;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2], ram_din [2], ram_dout [2];
  logic [AW-1:0] ram_addr [2];
  logic [31:0] mem [2][DEPTH];
  logic [31:0] stage [2], oreg [2];
  logic [31:0] ref_mem [2][DEPTH];
  int n_cmp = 0, n_bad = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_access_unit #(.RAM_DEPTH(DEPTH), .READ_LATENCY(2 - g)) dut (
      .clka(clka), .rsta(rsta[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_store(req_store[g]), .req_funct3(req_funct3[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .ram_addr(ram_addr[g]),
      .ram_din(ram_din[g]), .ram_we(ram_we[g]), .ram_en(ram_en[g]), .ram_regce(ram_regce[g]),
      .ram_rst(ram_rst[g]), .ram_dout(ram_dout[g])
    );
  end
  // write-first single-port RAMs: instance 0 uses the output register, instance 1 does not
  always @(posedge clka) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_en[g]) begin
        if (ram_we[g]) mem[g][ram_addr[g]] <= ram_din[g];
        stage[g] <= ram_we[g] ? ram_din[g] : mem[g][ram_addr[g]];
      end
      if (ram_rst[g]) oreg[g] <= 32'h0;
      else if (ram_regce[g]) oreg[g] <= stage[g];
    end
  end
  assign ram_dout[0] = oreg[0];
  assign ram_dout[1] = stage[1];
  initial clka = 1'b0;
  always #5 clka = ~clka;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // reference: RAM as an array of words, sub-word lanes addressed by byte offset
  task automatic model(input int i, input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] d,
                       output int lat, output int wes);
    int L, idx, off;
    logic [31:0] w;
    logic [7:0] b;
    logic [15:0] h;
    L = i == 0 ? 2 : 1;
    idx = int'((a >> 2) % DEPTH);
    off = int'(a % 4);
    w = ref_mem[i][idx];
    e = f == 3 || f >= 6 || (st && f >= 3) || ((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 0);
    d = 32'h0;
    wes = 0;
    if (e) lat = 1;
    else if (st) begin
      wes = 1;
      lat = f == 2 ? 2 : L + 3;
      if (f == 0) w[off*8 +: 8] = wd[7:0];
      else if (f == 1) w[(off/2)*16 +: 16] = wd[15:0];
      else w = wd;
      ref_mem[i][idx] = w;
    end else begin
      lat = L + 2;
      b = w[off*8 +: 8];
      h = w[(off/2)*16 +: 16];
      d = f == 0 ? {{24{b[7]}}, b} : f == 4 ? {24'h0, b} :
          f == 1 ? {{16{h[15]}}, h} : f == 5 ? {16'h0, h} : w;
    end
  endtask
  task automatic check_reset(input int i);
    chk("rst_req_ready", 32'(req_ready[i]), 1);
    chk("rst_resp_valid", 32'(resp_valid[i]), 0);
    chk("rst_resp_rdata", resp_rdata[i], 0);
    chk("rst_resp_err", 32'(resp_err[i]), 0);
    chk("rst_ram_en", 32'(ram_en[i]), 0);
    chk("rst_ram_we", 32'(ram_we[i]), 0);
    chk("rst_ram_regce", 32'(ram_regce[i]), 0);
    chk("rst_ram_addr", 32'(ram_addr[i]), 0);
    chk("rst_ram_din", ram_din[i], 0);
  endtask
  task automatic drive(input int i, input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid[i] = 1'b1;
    req_store[i] = st;
    req_funct3[i] = f;
    req_addr[i] = a;
    req_wdata[i] = wd;
    @(posedge clka);
    #1 req_valid[i] = 1'b0;
  endtask
  task automatic xact(input int i, input logic st, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, input int stall);
    logic e;
    logic [31:0] d;
    int exp_lat, exp_we, lat, we_n, en_n, we_at;
    model(i, st, f, a, wd, e, d, exp_lat, exp_we);
    chk("req_ready_idle", 32'(req_ready[i]), 1);
    resp_ready[i] = stall == 0;
    drive(i, st, f, a, wd);
    chk("req_ready_busy", 32'(req_ready[i]), 0);
    lat = 1;
    we_n = 0;
    en_n = 0;
    we_at = 0;
    while (!resp_valid[i] && lat < 40) begin
      en_n += int'(ram_en[i]);
      if (ram_we[i]) begin
        we_n++;
        we_at = lat;
      end
      @(posedge clka);
      #1 lat++;
    end
    chk("latency", lat, exp_lat);
    chk("resp_err", 32'(resp_err[i]), 32'(e));
    chk("resp_rdata", resp_rdata[i], d);
    chk("we_pulses", we_n, exp_we);
    if (e) chk("err_ram_en", en_n, 0);
    if (st && !e && f != 2) chk("rmw_we_at", we_at, exp_lat - 1);
    for (int k = 0; k < stall; k++) begin
      @(posedge clka);
      #1;
      chk("stall_valid", 32'(resp_valid[i]), 1);
      chk("stall_rdata", resp_rdata[i], d);
      chk("stall_req_ready", 32'(req_ready[i]), 0);
    end
    resp_ready[i] = 1'b1;
    @(posedge clka);
    #1 chk("after_handshake", 32'(resp_valid[i]), 0);
  endtask
  task automatic abort_sh(input int i, input logic [31:0] a);
    drive(i, 1'b1, 3'd1, a, $urandom);
    @(posedge clka);
    #1 chk("abort_in_wait", 32'(ram_regce[i]), 1);
    rsta[i] = 1'b1;
    #1 check_reset(i);
    #1 rsta[i] = 1'b0;
    repeat (5) begin
      @(posedge clka);
      #1;
      chk("abort_no_resp", 32'(resp_valid[i]), 0);
      chk("abort_no_we", 32'(ram_we[i]), 0);
    end
  endtask
  initial begin
    rsta = 2'b11;
    req_valid = 2'b00;
    req_store = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = 3'd0;
      req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0;
    end
    #2;
    check_reset(0);
    check_reset(1);
    #10 rsta = 2'b00;
    @(posedge clka);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < DEPTH; w++) xact(i, 1'b1, 3'd2, 32'(w * 4), $urandom, 0);
      xact(i, 1'b1, 3'd2, 32'h14, 32'h8899_aabb, 0);
      xact(i, 1'b0, 3'd0, 32'h16, 32'h0, 0);
      chk("lb_const", resp_rdata[i], 32'h0);
      xact(i, 1'b0, 3'd4, 32'h16, 32'h0, 0);
      xact(i, 1'b0, 3'd1, 32'h14, 32'h0, 0);
      xact(i, 1'b1, 3'd2, 32'h20, 32'h1234_5678, 0);
      xact(i, 1'b0, 3'd2, 32'h20, 32'h0, 0);
      xact(i, 1'b1, 3'd2, 32'h0c, 32'haabb_ccdd, 0);
      xact(i, 1'b1, 3'd0, 32'h0d, 32'h0000_00ee, 0);
      xact(i, 1'b0, 3'd2, 32'h0c, 32'h0, 0);
      xact(i, 1'b0, 3'd1, 32'h03, 32'h0, 0);
      xact(i, 1'b0, 3'd2, 32'h02, 32'h0, 0);
      xact(i, 1'b0, 3'd0, 32'h16, 32'h0, 10);
      abort_sh(i, 32'h0e);
      xact(i, 1'b0, 3'd2, 32'h0c, 32'h0, 0);
      for (int n = 0; n < 120; n++) begin
        logic [31:0] a;
        logic [2:0] f;
        f = 3'($urandom_range(0, 7));
        a = $urandom;
        if ($urandom_range(0, 3) != 0)
          a[1:0] = f[1:0] == 2'd0 ? a[1:0] : f[1:0] == 2'd1 ? {a[1], 1'b0} : 2'b00;
        xact(i, 1'($urandom_range(0, 1)), f, a, $urandom,
             $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 4)) : 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
